// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
package sram_bus_arbiter_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned SIZE_W   = 2;
    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/sram_arb_sel.sv
// Grant selection: data side wins unless fetch has been passed over STARVE_MAX times.
module sram_arb_sel
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic inst_req,
    input  logic data_req,
    output logic grant_inst,
    output logic grant_data
);

    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_at_max;

    assign starve_at_max = (starve_cnt == STARVE_W'(STARVE_MAX));

    always_comb begin
        grant_inst = idle && inst_req && (!data_req || starve_at_max);
        grant_data = idle && data_req && !grant_inst;
    end

    // Counter only moves on grant cycles; saturates so a forced fetch grant is guaranteed.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_inst) begin
            starve_cnt <= '0;
        end else if (grant_data) begin
            if (!inst_req) begin
                starve_cnt <= '0;
            end else if (!starve_at_max) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between fetch and load/store; one transaction in flight.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [SIZE_W-1:0] data_size,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [SIZE_W-1:0] mem_size,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e   state, state_next;
    owner_e   owner;
    mem_cmd_t cmd;
    logic     idle, grant_inst, grant_data;

    // Reset gates arbitration so nothing is granted during the reset cycle.
    assign idle = (state == ST_IDLE) && !reset;

    sram_arb_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clk        (clk),
        .reset      (reset),
        .idle       (idle),
        .inst_req   (inst_req),
        .data_req   (data_req),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_inst || grant_data) state_next = ST_REQ;
            ST_REQ:  if (mem_addr_ok)              state_next = ST_WAIT;
            ST_WAIT: if (mem_data_ok)              state_next = ST_IDLE;
            default:                               state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs; responses outside WAIT are protocol violations and dropped.
    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        if (state == ST_WAIT && mem_data_ok && !reset) begin
            if (owner == OWNER_INST) begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_rdata;
            end else begin
                data_data_ok = 1'b1;
                data_rdata   = mem_rdata;
            end
        end
    end

    // Request payload is captured on grant and cleared once memory accepts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner   <= OWNER_DATA;
            cmd     <= '0;
            mem_req <= 1'b0;
        end else if (grant_inst) begin
            owner   <= OWNER_INST;
            cmd     <= '{wr: 1'b0, size: SIZE_WORD, wstrb: '0, addr: inst_addr, wdata: '0};
            mem_req <= 1'b1;
        end else if (grant_data) begin
            owner   <= OWNER_DATA;
            cmd     <= '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                         addr: data_addr, wdata: data_wdata};
            mem_req <= 1'b1;
        end else if (state == ST_REQ && mem_addr_ok) begin
            cmd     <= '0;
            mem_req <= 1'b0;
        end
    end

    assign mem_wr    = cmd.wr;
    assign mem_size  = cmd.size;
    assign mem_wstrb = cmd.wstrb;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus a randomized run against a transaction model.
module tb_sram_bus_arbiter;

    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    wire [70:0] mem_bus  = {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};
    wire [65:0] resp_bus = {inst_data_ok, inst_rdata, data_data_ok, data_rdata};
    wire [1:0]  aok      = {inst_addr_ok, data_addr_ok};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_wstrb = '0;
        data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        inst_req = 1'b1;
        data_req = 1'b1;
        step();
        step();
        total++;
        if (aok !== 2'b00) begin
            bad++; $display("FAIL reset_addr_ok: got %b want 00", aok);
        end
        total++;
        if ({mem_req, mem_bus} !== 72'h0) begin
            bad++; $display("FAIL reset_mem: got %h want 0", {mem_req, mem_bus});
        end
        total++;
        if (resp_bus !== 66'h0) begin
            bad++; $display("FAIL reset_resp: got %h want 0", resp_bus);
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        reset = 1'b0;
        step();
        total++;
        if ({aok, mem_req, mem_bus, resp_bus} !== 140'h0) begin
            bad++; $display("FAIL idle_quiet: got %h want 0", {aok, mem_req, mem_bus, resp_bus});
        end
    endtask

    task automatic test_lone_fetch();
        do_reset();
        inst_req = 1'b1;
        inst_addr = 32'h1C00_0000;
        #1;
        total++;
        if (aok !== 2'b10) begin
            bad++; $display("FAIL fetch_addr_ok: got %b want 10", aok);
        end
        step();
        inst_req = 1'b0;
        #1;
        total++;
        if ({mem_req, mem_bus} !== {1'b1, 1'b0, 2'd2, 4'h0, 32'h1C00_0000, 32'h0}) begin
            bad++; $display("FAIL fetch_mem_req: got %h want %h", {mem_req, mem_bus},
                            {1'b1, 1'b0, 2'd2, 4'h0, 32'h1C00_0000, 32'h0});
        end
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata = 32'h0280_0C0C;
        #1;
        total++;
        if ({mem_req, resp_bus} !== {1'b0, 1'b1, 32'h0280_0C0C, 1'b0, 32'h0}) begin
            bad++; $display("FAIL fetch_data_ok: got %h want %h", {mem_req, resp_bus},
                            {1'b0, 1'b1, 32'h0280_0C0C, 1'b0, 32'h0});
        end
        step();
        mem_data_ok = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        inst_req = 1'b1; inst_addr = 32'h0000_0400;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h100; data_wstrb = 4'h3;
        data_size = 2'd1; data_wdata = 32'hBEEF;
        #1;
        total++;
        if (aok !== 2'b01) begin
            bad++; $display("FAIL sim_data_first: got %b want 01", aok);
        end
        step();
        data_req = 1'b0;
        #1;
        total++;
        if ({aok, mem_req, mem_bus} !== {2'b00, 1'b1, 1'b1, 2'd1, 4'h3, 32'h100, 32'hBEEF}) begin
            bad++; $display("FAIL sim_store_cmd: got %h want %h", {aok, mem_req, mem_bus},
                            {2'b00, 1'b1, 1'b1, 2'd1, 4'h3, 32'h100, 32'hBEEF});
        end
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        total++;
        if ({aok, resp_bus} !== {2'b00, 1'b0, 32'h0, 1'b1, 32'h1234_5678}) begin
            bad++; $display("FAIL sim_store_done: got %h want %h", {aok, resp_bus},
                            {2'b00, 1'b0, 32'h0, 1'b1, 32'h1234_5678});
        end
        step();
        mem_data_ok = 1'b0;
        #1;
        total++;
        if (aok !== 2'b10) begin
            bad++; $display("FAIL sim_inst_second: got %b want 10", aok);
        end
        step();
        inst_req = 1'b0;
        #1;
        total++;
        if ({mem_req, mem_addr, mem_wr} !== {1'b1, 32'h400, 1'b0}) begin
            bad++; $display("FAIL sim_inst_cmd: got %h want %h", {mem_req, mem_addr, mem_wr},
                            {1'b1, 32'h400, 1'b0});
        end
    endtask

    task automatic test_starvation();
        bit exp_inst [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int n = 0;
        do_reset();
        inst_req = 1'b1; inst_addr = 32'h8;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h20;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h55;
        for (int c = 0; c < 40 && n < 10; c++) begin
            #1;
            if (inst_addr_ok || data_addr_ok) begin
                total++;
                if ({inst_addr_ok, data_addr_ok} !== {exp_inst[n], !exp_inst[n]}) begin
                    bad++; $display("FAIL starve_grant_%0d: got %b want %b", n,
                                    {inst_addr_ok, data_addr_ok}, {exp_inst[n], !exp_inst[n]});
                end
                n++;
            end
            step();
        end
        total++;
        if (n != 10) begin
            bad++; $display("FAIL starve_timeout: got %0d grants want 10", n);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h200;
        #1;
        total++;
        if (aok !== 2'b01) begin
            bad++; $display("FAIL stall_grant: got %b want 01", aok);
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 1) data_req = 1'b0;
            if (i == 2) begin
                data_req = 1'b1;
                data_addr = 32'h300;
            end
            if (i == 6) mem_addr_ok = 1'b1;
            #1;
            total++;
            if ({mem_req, mem_addr, aok} !== {1'b1, 32'h200, 2'b00}) begin
                bad++; $display("FAIL stall_hold_%0d: got %h want %h", i,
                                {mem_req, mem_addr, aok}, {1'b1, 32'h200, 2'b00});
            end
        end
        step();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        total++;
        if ({aok, resp_bus} !== {2'b00, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D}) begin
            bad++; $display("FAIL stall_resp: got %h want %h", {aok, resp_bus},
                            {2'b00, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D});
        end
        step();
        mem_data_ok = 1'b0;
        #1;
        total++;
        if (aok !== 2'b01) begin
            bad++; $display("FAIL stall_late_grant: got %b want 01", aok);
        end
        step();
        data_req = 1'b0;
        #1;
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin
            bad++; $display("FAIL stall_second_cmd: got %h want %h", {mem_req, mem_addr},
                            {1'b1, 32'h300});
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        inst_req = 1'b1; inst_addr = 32'h40;
        step();
        inst_req = 1'b0;
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        total++;
        if ({aok, mem_req, mem_bus, resp_bus} !== 140'h0) begin
            bad++; $display("FAIL rst_wait_drop: got %h want 0", {aok, mem_req, mem_bus, resp_bus});
        end
        step();
        mem_data_ok = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h80;
        #1;
        total++;
        if (aok !== 2'b10) begin
            bad++; $display("FAIL rst_wait_regrant: got %b want 10", aok);
        end
        step();
        inst_req = 1'b0;
        #1;
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin
            bad++; $display("FAIL rst_wait_cmd: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h80});
        end
    endtask

    task automatic test_spurious_data_ok();
        do_reset();
        mem_data_ok = 1'b1;
        mem_rdata = $urandom;
        #1;
        total++;
        if (resp_bus !== 66'h0) begin
            bad++; $display("FAIL spurious_idle: got %h want 0", resp_bus);
        end
        mem_data_ok = 1'b0;
        inst_req = 1'b1; inst_addr = 32'hC;
        step();
        inst_req = 1'b0;
        mem_data_ok = 1'b1;
        #1;
        total++;
        if ({mem_req, resp_bus} !== {1'b1, 66'h0}) begin
            bad++; $display("FAIL spurious_req: got %h want %h", {mem_req, resp_bus}, {1'b1, 66'h0});
        end
        step();
        mem_data_ok = 1'b0;
    endtask

    // Transaction-level model: pending requests, one in-flight command, a pass-over count.
    task automatic test_random();
        bit          i_pend = 0, d_pend = 0, busy = 0, acc = 0, own_inst = 0;
        bit          g_i, g_d, r;
        int          cnt = 0;
        logic [70:0] exp_cmd = '0;
        logic [65:0] exp_resp;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!i_pend && ($urandom_range(0, 2) == 0)) begin
                i_pend = 1;
                inst_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend && ($urandom_range(0, 2) == 0)) begin
                d_pend = 1;
                data_wr = 1'($urandom);
                data_size = 2'($urandom_range(0, 2));
                data_wstrb = 4'($urandom);
                data_addr = $urandom;
                data_wdata = $urandom;
            end
            inst_req = i_pend;
            data_req = d_pend;
            mem_addr_ok = 1'($urandom);
            mem_data_ok = 1'($urandom);
            mem_rdata = $urandom;
            #1;
            g_i = !busy && i_pend && (!d_pend || cnt == STARVE_MAX);
            g_d = !busy && d_pend && !g_i;
            total++;
            if (aok !== {g_i, g_d}) begin
                bad++; $display("FAIL rnd_grant c%0d: got %b want %b", c, aok, {g_i, g_d});
            end
            total++;
            if ({mem_req, mem_bus} !== ((busy && !acc) ? {1'b1, exp_cmd} : 72'h0)) begin
                bad++; $display("FAIL rnd_mem c%0d: got %h want %h", c, {mem_req, mem_bus},
                                (busy && !acc) ? {1'b1, exp_cmd} : 72'h0);
            end
            r = busy && acc && mem_data_ok;
            exp_resp = {r && own_inst, (r && own_inst) ? mem_rdata : 32'h0,
                        r && !own_inst, (r && !own_inst) ? mem_rdata : 32'h0};
            total++;
            if (resp_bus !== exp_resp) begin
                bad++; $display("FAIL rnd_resp c%0d: got %h want %h", c, resp_bus, exp_resp);
            end
            if (busy) begin
                if (!acc) acc = mem_addr_ok;
                else if (mem_data_ok) busy = 0;
            end
            if (g_i) begin
                busy = 1; acc = 0; own_inst = 1; cnt = 0; i_pend = 0;
                exp_cmd = {1'b0, 2'd2, 4'h0, inst_addr, 32'h0};
            end
            if (g_d) begin
                busy = 1; acc = 0; own_inst = 0; d_pend = 0;
                cnt = i_pend ? ((cnt < STARVE_MAX) ? cnt + 1 : STARVE_MAX) : 0;
                exp_cmd = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_starvation();
        test_backpressure();
        test_reset_in_wait();
        test_spurious_data_ok();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
